pipe_add: RTL

- Parameterised, pipelined two's-complement adder/subtractor.
- Splits a WIDTH-bit operation into NSEG = WIDTH/SEG segments. Each pipeline stage adds one SEG-bit segment and registers its carry into the next stage.
- Sustains one operation per cycle at a clock rate independent of WIDTH.
- Sits between operand producers and result consumers on valid/ready streams; it is the successor to the single-cycle ripple adder.

---
 rtl/arith_pkg.sv | 25 ++
 rtl/add_seg.sv | 33 +++
 rtl/pipe_add.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the segmented pipelined adder.
// Provides the operation-mode encoding, the carry-in forced in subtract
// mode, and elaboration helpers that validate WIDTH/SEG and derive the
// number of pipeline segments.
package arith_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // a - b is formed as a + ~b + 1, so subtract mode injects a carry of one.
    localparam logic SUB_CIN = 1'b1;

    function automatic bit seg_ok(input int width, input int seg);
        return (seg >= 1) && (seg <= width) && ((width % seg) == 0);
    endfunction

    // Guard the division so a bad SEG reaches the elaboration error
    // instead of a divide-by-zero.
    function automatic int calc_nseg(input int width, input int seg);
        return (seg >= 1) ? (width / seg) : 1;
    endfunction

endpackage

// File: rtl/add_seg.sv
// Combinational SEG-bit adder slice.
// Ports:
//   a, b      in  SEG  operand segments
//   ci        in  1    carry into bit 0
//   s         out SEG  segment sum
//   co        out 1    carry out of bit SEG-1
//   c_msb_in  out 1    carry into bit SEG-1 (signed-overflow detection)
module add_seg
    import arith_pkg::*;
#(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb_in
);

    logic [SEG:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
    end

    assign s  = total[SEG-1:0];
    assign co = total[SEG];
    // The top sum bit is a ^ b ^ carry-in at that bit, so the carry-in
    // can be recovered without a second adder.
    assign c_msb_in = a[SEG-1] ^ b[SEG-1] ^ total[SEG-1];

endmodule

// File: rtl/pipe_add.sv
// Pipelined two's-complement adder/subtractor on valid/ready streams.
// A WIDTH-bit add is split into NSEG = WIDTH/SEG segments; stage k adds
// segment k and registers its carry for stage k+1. Latency NSEG cycles,
// throughput one operation per cycle. The whole pipeline advances in
// lock-step whenever the output register is empty or being drained.
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid/in_ready    operand handshake
//   a, b                 operands (WIDTH)
//   cin                  carry-in, add mode only
//   sub                  0: a+b+cin, 1: a-b
//   out_valid/out_ready  result handshake
//   sum                  result modulo 2^WIDTH
//   cout                 carry out of MSB (no-borrow when subtracting)
//   ovf                  signed overflow
module pipe_add
    import arith_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = calc_nseg(WIDTH, SEG);

    generate
        if (!seg_ok(WIDTH, SEG)) begin : g_param_err
            $error("pipe_add: WIDTH (%0d) must be a positive multiple of SEG (%0d)", WIDTH, SEG);
        end
    endgenerate

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Stage registers: valid, carry out of the stage's segment, skewed
    // operands (upper segments still to be added) and partial result.
    logic [NSEG-1:0]  vld_q, vld_d;
    logic [NSEG-1:0]  carry_q, carry_d;
    logic [WIDTH-1:0] a_q   [NSEG];
    logic [WIDTH-1:0] a_d   [NSEG];
    logic [WIDTH-1:0] b_q   [NSEG];
    logic [WIDTH-1:0] b_d   [NSEG];
    logic [WIDTH-1:0] res_q [NSEG];
    logic [WIDTH-1:0] res_d [NSEG];
    logic             ovf_q, ovf_d;

    // Inputs seen by each stage: the accepted operands for stage 0, the
    // previous stage's registers otherwise.
    logic [WIDTH-1:0] a_in  [NSEG];
    logic [WIDTH-1:0] b_in  [NSEG];
    logic [WIDTH-1:0] r_in  [NSEG];
    logic [NSEG-1:0]  c_in;
    logic [NSEG-1:0]  v_in;

    logic [SEG-1:0]   s_w   [NSEG];
    logic [NSEG-1:0]  co_w;
    logic             cm_w  [NSEG];

    assign advance  = !vld_q[NSEG-1] | out_ready;
    assign in_ready = advance;

    always_comb begin
        b_eff = (op_e'(sub) == OP_SUB) ? ~b : b;
        c0    = (op_e'(sub) == OP_SUB) ? SUB_CIN : cin;

        a_in[0] = a;
        b_in[0] = b_eff;
        r_in[0] = '0;
        c_in[0] = c0;
        v_in[0] = in_valid;
        for (int k = 1; k < NSEG; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            r_in[k] = res_q[k-1];
            c_in[k] = carry_q[k-1];
            v_in[k] = vld_q[k-1];
        end
    end

    generate
        for (genvar k = 0; k < NSEG; k++) begin : g_seg
            add_seg #(
                .SEG(SEG)
            ) u_add_seg (
                .a        (a_in[k][k*SEG +: SEG]),
                .b        (b_in[k][k*SEG +: SEG]),
                .ci       (c_in[k]),
                .s        (s_w[k]),
                .co       (co_w[k]),
                .c_msb_in (cm_w[k])
            );
        end
    endgenerate

    // Valid bits follow the global advance so bubbles keep their slot.
    // Data only loads behind a valid token; bubbles leave the previous
    // contents in place, which keeps sum at the last delivered value.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            vld_d[k]   = vld_q[k];
            carry_d[k] = carry_q[k];
            a_d[k]     = a_q[k];
            b_d[k]     = b_q[k];
            res_d[k]   = res_q[k];
            if (advance) begin
                vld_d[k] = v_in[k];
                if (v_in[k]) begin
                    carry_d[k]               = co_w[k];
                    a_d[k]                   = a_in[k];
                    b_d[k]                   = b_in[k];
                    res_d[k]                 = r_in[k];
                    res_d[k][k*SEG +: SEG]   = s_w[k];
                end
            end
        end

        ovf_d = ovf_q;
        if (advance && v_in[NSEG-1]) begin
            ovf_d = cm_w[NSEG-1] ^ co_w[NSEG-1];
        end
    end

    // ---- stage registers (segment k result captured at edge T+k) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < NSEG; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                res_q[k] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // ---- output stage ----
    assign out_valid = vld_q[NSEG-1];
    assign sum       = res_q[NSEG-1];
    assign cout      = carry_q[NSEG-1];
    assign ovf       = ovf_q;

endmodule
